// File: rtl/s386_resp_misr.sv
// rtl/s386_resp_misr.sv - MISR response compactor for the s386 core outputs
// Folds N_PAT valid 7-bit vectors into a signature and compares against EXP_SIG.
module s386_resp_misr #(
    parameter int             W     = 7,
    parameter int             CNT_W = 16,
    parameter logic [W-1:0]   POLY  = 7'h03,
    parameter logic [W-1:0]   SEED  = 7'h00
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic [CNT_W-1:0] N_PAT,
    input  logic [W-1:0]     EXP_SIG,
    input  logic [W-1:0]     DIN,
    input  logic             DIN_VLD,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [W-1:0]     SIG,
    output logic [CNT_W-1:0] CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] npat_q, npat_d;
    logic [W-1:0]     exp_q, exp_d;
    logic             pass_q, pass_d;
    logic [W-1:0]     sig_step;

    // Galois-style shift with feedback into the low taps, then fold in the vector.
    assign sig_step = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ DIN;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        npat_d  = npat_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    sig_d  = SEED;
                    cnt_d  = '0;
                    npat_d = N_PAT;
                    exp_d  = EXP_SIG;
                    if (N_PAT == '0) begin
                        state_d = ST_DONE;
                        pass_d  = (SEED == EXP_SIG);
                    end else begin
                        state_d = ST_RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (DIN_VLD) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    // npat_q is at least 1 here, so the subtraction cannot underflow.
                    if (cnt_q == npat_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_step == exp_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            npat_q  <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            npat_q  <= npat_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);
    assign PASS = pass_q;
    assign SIG  = sig_q;
    assign CNT  = cnt_q;

endmodule

// File: tb/tb_s386_resp_misr.sv
// tb/tb_s386_resp_misr.sv - scoreboard bench for s386_resp_misr
module tb_s386_resp_misr;

    localparam int           W     = 7;
    localparam int           CNT_W = 16;
    localparam logic [W-1:0] POLY  = 7'h03;
    localparam logic [W-1:0] SEED  = 7'h00;

    logic             ck;
    logic             rn;
    logic             start;
    logic [CNT_W-1:0] n_pat;
    logic [W-1:0]     exp_sig;
    logic [W-1:0]     din;
    logic             din_vld;
    logic             busy, done, pass;
    logic [W-1:0]     sig;
    logic [CNT_W-1:0] cnt;

    s386_resp_misr #(.W(W), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)) dut (
        .CK(ck), .RN(rn), .START(start), .N_PAT(n_pat), .EXP_SIG(exp_sig),
        .DIN(din), .DIN_VLD(din_vld), .BUSY(busy), .DONE(done), .PASS(pass),
        .SIG(sig), .CNT(cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic             busy;
        logic             done;
        logic             pass;
        logic [W-1:0]     sig;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    int               m_st = 0; // 0 idle, 1 run, 2 done
    logic [W-1:0]     m_sig = '0, m_exp = '0;
    logic [CNT_W-1:0] m_cnt = '0, m_npat = '0;
    logic             m_pass = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] misr(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] sh;
        sh = s << 1;
        if (s[W-1]) sh = sh ^ POLY;
        return sh ^ d;
    endfunction

    task automatic model_edge();
        logic [W-1:0] nx;
        if (!rn) begin
            m_st = 0; m_sig = '0; m_cnt = '0; m_npat = '0; m_exp = '0; m_pass = 1'b0;
        end else if (m_st != 1) begin
            if (start) begin
                m_sig = SEED; m_cnt = '0; m_npat = n_pat; m_exp = exp_sig;
                if (n_pat == 0) begin
                    m_st = 2; m_pass = (SEED == exp_sig);
                end else begin
                    m_st = 1; m_pass = 1'b0;
                end
            end
        end else if (din_vld) begin
            nx = misr(m_sig, din);
            if (m_cnt == m_npat - 1) begin
                m_st = 2; m_pass = (nx == m_exp);
            end
            m_sig = nx;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic cyc(input logic r, input logic s, input int np, input logic [W-1:0] e,
                       input logic [W-1:0] d, input logic v);
        exp_t x;
        rn = r; start = s; n_pat = CNT_W'(np); exp_sig = e; din = d; din_vld = v;
        model_edge();
        x.busy = (m_st == 1); x.done = (m_st == 2); x.pass = m_pass;
        x.sig = m_sig; x.cnt = m_cnt;
        exp_q.push_back(x);
        @(posedge ck);
        #1;
        x = exp_q.pop_front();
        check("sb_busy", 32'(busy), 32'(x.busy));
        check("sb_done", 32'(done), 32'(x.done));
        check("sb_pass", 32'(pass), 32'(x.pass));
        check("sb_sig",  32'(sig),  32'(x.sig));
        check("sb_cnt",  32'(cnt),  32'(x.cnt));
    endtask

    task automatic vec(input logic [W-1:0] d);
        cyc(1'b1, 1'b0, 0, 7'h00, d, 1'b1);
    endtask

    initial begin
        rn = 1'b0; start = 1'b0; n_pat = '0; exp_sig = '0; din = '0; din_vld = 1'b0;
        @(posedge ck); #1;

        // reset dominates START and DIN_VLD
        cyc(1'b0, 1'b1, 2, 7'h11, 7'h7F, 1'b1);
        cyc(1'b0, 1'b1, 2, 7'h11, 7'h7F, 1'b1);
        check("rst_sig", 32'(sig), 32'h0);
        check("rst_cnt", 32'(cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pass", 32'(pass), 32'h0);

        // basic pass; vector alongside START is not compacted
        cyc(1'b1, 1'b1, 2, 7'h03, 7'h7F, 1'b1);
        check("bp_start_sig", 32'(sig), 32'(SEED));
        check("bp_start_busy", 32'(busy), 32'h1);
        vec(7'h40);
        check("bp_sig1", 32'(sig), 32'h40);
        vec(7'h00);
        check("bp_sig2", 32'(sig), 32'h03);
        check("bp_done", 32'(done), 32'h1);
        check("bp_pass", 32'(pass), 32'h1);
        check("bp_cnt", 32'(cnt), 32'h2);
        check("bp_busy", 32'(busy), 32'h0);
        vec(7'h55);
        check("bp_frozen", 32'(sig), 32'h03);

        // gaps and fail
        cyc(1'b1, 1'b1, 2, 7'h05, 7'h00, 1'b0);
        vec(7'h01);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 0, 7'h00, 7'h7F, 1'b0);
            check("gap_hold", 32'(sig), 32'h01);
        end
        vec(7'h02);
        check("gap_sig", 32'(sig), 32'h00);
        check("gap_cnt", 32'(cnt), 32'h2);
        check("gap_done", 32'(done), 32'h1);
        check("gap_pass", 32'(pass), 32'h0);

        // zero length
        cyc(1'b1, 1'b1, 0, 7'h00, 7'h00, 1'b0);
        check("zl_done", 32'(done), 32'h1);
        check("zl_pass", 32'(pass), 32'h1);
        check("zl_cnt", 32'(cnt), 32'h0);
        check("zl_sig", 32'(sig), 32'(SEED));
        cyc(1'b1, 1'b1, 0, 7'h01, 7'h00, 1'b0);
        check("zl_fail", 32'(pass), 32'h0);

        // START during RUN ignored (vector on that edge still compacted)
        cyc(1'b1, 1'b1, 3, 7'h00, 7'h00, 1'b0);
        vec(7'h21);
        cyc(1'b1, 1'b1, 3, 7'h00, 7'h12, 1'b1);
        check("ign_cnt", 32'(cnt), 32'h2);
        check("ign_done0", 32'(done), 32'h0);
        vec(7'h33);
        check("ign_done", 32'(done), 32'h1);
        check("ign_cnt3", 32'(cnt), 32'h3);
        cyc(1'b1, 1'b1, 4, 7'h00, 7'h00, 1'b0);
        check("rs_cnt", 32'(cnt), 32'h0);
        check("rs_sig", 32'(sig), 32'(SEED));
        check("rs_busy", 32'(busy), 32'h1);

        // reset mid-RUN
        cyc(1'b0, 1'b0, 0, 7'h00, 7'h00, 1'b0);
        cyc(1'b1, 1'b1, 10, 7'h00, 7'h00, 1'b0);
        for (int i = 0; i < 5; i++) vec(7'($urandom_range(1, 127)));
        cyc(1'b0, 1'b0, 0, 7'h00, 7'h3C, 1'b1);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_sig", 32'(sig), 32'h0);
        check("mr_cnt", 32'(cnt), 32'h0);
        for (int i = 0; i < 3; i++) begin
            vec(7'h7F);
            check("mr_idle_sig", 32'(sig), 32'h0);
        end

        // random runs; half use the model's signature as EXP to hit PASS=1
        for (int r = 0; r < 8; r++) begin
            int np;
            logic [W-1:0] data[$];
            logic [W-1:0] s;
            np = $urandom_range(1, 9);
            s = SEED;
            data.delete();
            for (int i = 0; i < np; i++) begin
                data.push_back(7'($urandom));
                s = misr(s, data[i]);
            end
            cyc(1'b1, 1'b1, np, (r % 2 == 0) ? s : ~s, 7'h00, 1'b0);
            for (int i = 0; i < np; i++) begin
                if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, 0, 7'h00, 7'($urandom), 1'b0);
                vec(data[i]);
            end
            check("rnd_pass", 32'(pass), (r % 2 == 0) ? 32'h1 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s386_resp_misr.md
Name: s386_resp_misr

Overview:
- Response compactor directly downstream of the s386 sequential benchmark core.
- Consumes the core's 7 primary outputs (v13_D_12..v13_D_6) once per valid cycle and folds them into a multiple-input signature register (MISR) over a programmed pattern count.
- Compares the final signature against an expected value and reports pass/fail with a start/busy/done handshake to the test controller.

Parameters:
- W, 7, data and signature width; matches the s386 output count.
- CNT_W, 16, width of the pattern counter and N_PAT.
- POLY, 7'h03, feedback mask for the low bits (x^7+x+1); width W.
- SEED, 7'h00, signature value loaded on START; width W.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- RN  in  1  synchronous active-low reset, sampled on CK rising edge.
- START  in  1  single-cycle start request.
- N_PAT  in  CNT_W  number of valid vectors to compact; sampled with START.
- EXP_SIG  in  W  expected final signature; sampled with START.
- DIN  in  W  DIN[6]=v13_D_12 ... DIN[0]=v13_D_6.
- DIN_VLD  in  1  DIN is a vector to compact this cycle.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in DONE; level, held until next START.
- PASS  out  1  SIG==EXP_SIG at completion; valid only while DONE=1.
- SIG  out  W  current signature.
- CNT  out  CNT_W  vectors compacted since last START.

Behaviour:
- Reset (RN=0 at an edge): state=IDLE, SIG=0, CNT=0, BUSY=0, DONE=0, PASS=0, latched N_PAT and EXP_SIG=0. Reset wins over every other input, including mid-RUN.
- MISR step: SIG_next = {SIG[W-2:0],1'b0} ^ (SIG[W-1] ? POLY : 0) ^ DIN. All arithmetic is modulo 2^W; no overflow flag.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On START: SIG<=SEED, CNT<=0, latch N_PAT and EXP_SIG.
  - If N_PAT==0: go to DONE with PASS<=(SEED==EXP_SIG). Otherwise go to RUN.
  - DIN_VLD is ignored in IDLE.
- RUN (BUSY=1):
  - Each edge with DIN_VLD=1: SIG<=SIG_next, CNT<=CNT+1.
  - DIN_VLD=0: SIG and CNT hold.
  - When DIN_VLD=1 and CNT==N_PAT-1: transition to DONE on the same edge, PASS<=(SIG_next==EXP_SIG).
  - START during RUN is ignored.
- DONE (DONE=1, BUSY=0):
  - SIG, CNT and PASS are frozen; DIN_VLD is ignored.
  - START behaves exactly as in IDLE (restart, including the N_PAT==0 case).
- Latency:
  - DIN sampled at edge k is reflected in SIG after edge k.
  - DONE rises on the edge that consumes the N_PAT-th valid vector.
  - Minimum START-to-DONE is N_PAT edges after the START edge, with DIN_VLD held high.
- CNT cannot wrap, because the FSM leaves RUN at N_PAT (at most 2^CNT_W-1).
- START and DIN_VLD asserted together in IDLE/DONE: START is taken, and the vector is not compacted.

Test Plan:
- Reset: hold RN=0 for 2 cycles with START=1, DIN=7'h7F, DIN_VLD=1 -> SIG=0, CNT=0, BUSY=0, DONE=0, PASS=0.
- Basic pass: START with N_PAT=2, EXP_SIG=7'h03, then DIN=7'h40 and DIN=7'h00 with DIN_VLD=1 -> SIG=7'h40 after the 1st vector and 7'h03 after the 2nd. DONE=1 and PASS=1 on the 2nd edge; CNT=2; BUSY=0.
- Gaps and fail: START with N_PAT=2, EXP_SIG=7'h05, then DIN=7'h01 (VLD=1), 3 idle cycles (VLD=0, DIN=7'h7F), then DIN=7'h02 (VLD=1) -> SIG=7'h01 held through the gap, final SIG=7'h00, CNT=2, DONE=1, PASS=0.
- Zero length: START with N_PAT=0, EXP_SIG=7'h00 -> DONE=1 and PASS=1 one edge after START; CNT=0; SIG=SEED.
- Ignored restart, then restart from DONE: START with N_PAT=3; pulse START again after 1 vector -> no effect, and DONE rises after the 3rd vector. START from DONE -> CNT=0, SIG=SEED, BUSY=1.
- Reset mid-RUN: drive RN=0 after 5 of 10 vectors -> all outputs return to reset values; following DIN_VLD pulses leave SIG=0 until the next START.
